// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX load target.
import pipeline_ctrl_pkg::*;

module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic hit1;
    logic hit2;

    assign hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
    assign hit2 = id_uses_rs2 && (id_rs2 == ex_rd);

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO)
                   && (hit1 || hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline registers and PC.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch,
    input  logic             mem_jump,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic             memwb_clr,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e state;
    logic   load_use;
    logic   redirect;
    logic   mem_stall;

    hazard_detect u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    assign redirect  = mem_branch || mem_jump;
    assign mem_stall = mem_access && !dmem_ready;

    always_comb begin
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_clr    = 1'b0;
        idex_clr    = 1'b0;
        exmem_clr   = 1'b0;
        memwb_clr   = 1'b0;
        bubble      = 1'b0;
        if (clr) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
            memwb_clr = 1'b1;
        end else begin
            dmem_req = mem_access && (state != MEM_WAIT);
            if (mem_stall) begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_en  = 1'b0;
                memwb_clr = 1'b1;
                bubble    = 1'b1;
            end else if (redirect) begin
                pc_redirect = 1'b1;
                ifid_clr    = 1'b1;
                idex_clr    = 1'b1;
                exmem_clr   = 1'b1;
                bubble      = 1'b1;
            end else if (state == DRAIN) begin
                // Drop the word fetched while the target was selected.
                ifid_clr = 1'b1;
            end else if (load_use) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
                bubble   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN, DRAIN: begin
                    if (mem_stall)
                        state <= MEM_WAIT;
                    else if (redirect)
                        state <= DRAIN;
                    else
                        state <= RUN;
                end
                MEM_WAIT: begin
                    if (dmem_ready)
                        state <= redirect ? DRAIN : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr)
            stall_cycles <= '0;
        else if (!pc_en && !(&stall_cycles))
            stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a rule-level model.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       mem_branch, mem_jump, mem_access, dmem_ready;

    logic        dmem_req, pc_en, pc_redirect, ifid_en, idex_en, exmem_en;
    logic        ifid_clr, idex_clr, exmem_clr, memwb_clr, bubble;
    logic [15:0] stall_cycles;

    logic        q_req, q_pc, q_redir, q_ifen, q_iden, q_exen;
    logic        q_ifc, q_idc, q_exc, q_wbc, q_bub;
    logic [3:0]  stall4;

    logic [10:0] vec, vec4;
    assign vec  = {dmem_req, pc_en, pc_redirect, ifid_en, idex_en, exmem_en,
                   ifid_clr, idex_clr, exmem_clr, memwb_clr, bubble};
    assign vec4 = {q_req, q_pc, q_redir, q_ifen, q_iden, q_exen,
                   q_ifc, q_idc, q_exc, q_wbc, q_bub};

    pipeline_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .clr(clr),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_branch(mem_branch), .mem_jump(mem_jump),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en), .pc_redirect(pc_redirect),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
        .bubble(bubble), .stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .clr(clr),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_branch(mem_branch), .mem_jump(mem_jump),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .dmem_req(q_req), .pc_en(q_pc), .pc_redirect(q_redir),
        .ifid_en(q_ifen), .idex_en(q_iden), .exmem_en(q_exen),
        .ifid_clr(q_ifc), .idex_clr(q_idc),
        .exmem_clr(q_exc), .memwb_clr(q_wbc),
        .bubble(q_bub), .stall_cycles(stall4)
    );

    int checks = 0;
    int passed = 0;

    // Model state: waiting on memory, draining after redirect, counters.
    bit m_wait, m_drain;
    int m_cnt, m_cnt4;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        clr = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
        mem_branch = 0; mem_jump = 0; mem_access = 0; dmem_ready = 0;
    endtask

    task automatic cycle(string tag);
        bit lu, rd, ms;
        bit dr, pe, pr, fe, de, xe, fc, dc, xc, wc, bb;
        @(negedge clk);
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) ||
              (id_uses_rs2 && id_rs2 == ex_rd));
        rd = mem_branch || mem_jump;
        ms = mem_access && !dmem_ready;
        {dr, pe, pr, fe, de, xe, fc, dc, xc, wc, bb} = 11'b01011100000;
        if (clr) begin
            {pe, fe, de, xe} = 4'b0000;
            {fc, dc, xc, wc} = 4'b1111;
        end else begin
            dr = mem_access && !m_wait;
            if (ms) begin
                {pe, fe, de, xe} = 4'b0000;
                wc = 1; bb = 1;
            end else if (rd) begin
                pr = 1; fc = 1; dc = 1; xc = 1; bb = 1;
            end else if (m_drain) begin
                fc = 1;
            end else if (lu) begin
                pe = 0; fe = 0; dc = 1; bb = 1;
            end
        end
        chk({tag, "_out"}, 32'(vec), 32'({dr, pe, pr, fe, de, xe,
                                          fc, dc, xc, wc, bb}));
        chk({tag, "_out4"}, 32'(vec4), 32'({dr, pe, pr, fe, de, xe,
                                            fc, dc, xc, wc, bb}));
        chk({tag, "_cnt"}, 32'(stall_cycles), m_cnt);
        chk({tag, "_cnt4"}, 32'(stall4), m_cnt4);
        @(posedge clk);
        if (clr) begin
            m_wait = 0; m_drain = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (!pe) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (m_wait) begin
                if (dmem_ready) begin
                    m_wait = 0; m_drain = rd;
                end
            end else if (ms) begin
                m_wait = 1; m_drain = 0;
            end else begin
                m_drain = rd;
            end
        end
        #1;
    endtask

    initial begin
        idle();
        clr = 1;
        @(posedge clk);
        #1;
        m_wait = 0; m_drain = 0; m_cnt = 0; m_cnt4 = 0;
        cycle("rst");
        clr = 0;

        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        cycle("lu");
        chk("lu_count", 32'(stall_cycles), 1);
        idle();
        cycle("lu_done");
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
        cycle("lu_x0");
        chk("lu_x0_count", 32'(stall_cycles), 1);
        idle();

        mem_access = 1;
        repeat (3) cycle("mwait");
        dmem_ready = 1;
        cycle("mrel");
        chk("mwait_count", 32'(stall_cycles), 4);
        idle();

        mem_jump = 1;
        cycle("jump");
        idle();
        cycle("drain");
        cycle("after_drain");
        chk("jump_count", 32'(stall_cycles), 4);

        mem_access = 1; ex_mem_read = 1; ex_rd = 7;
        id_rs1 = 7; id_uses_rs1 = 1;
        repeat (2) cycle("ms_lu");
        dmem_ready = 1;
        cycle("ms_lu_rel");
        idle();
        cycle("ms_lu_idle");

        mem_access = 1;
        cycle("clr_a");
        cycle("clr_b");
        clr = 1;
        cycle("clr_mid");
        chk("clr_count", 32'(stall_cycles), 0);
        idle();
        cycle("clr_post");

        mem_access = 1;
        repeat (20) cycle("sat");
        chk("sat4", 32'(stall4), 15);
        chk("sat16", 32'(stall_cycles), 20);
        dmem_ready = 1;
        cycle("sat_rel");
        idle();

        for (int i = 0; i < 400; i++) begin
            clr         = ($urandom_range(0, 39) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom);
            id_uses_rs2 = 1'($urandom);
            ex_mem_read = 1'($urandom);
            mem_branch  = ($urandom_range(0, 7) == 0);
            mem_jump    = ($urandom_range(0, 9) == 0);
            mem_access  = ($urandom_range(0, 2) == 0);
            dmem_ready  = 1'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
